// File: rtl/sli_reset_sequencer.sv
// Reset sequencer: synchronises the board nreset, then releases domain resets one at a time,
// STAGE_DELAY cycles apart. A four-phase software-reset handshake re-runs the sequence.
module sli_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_DOMAINS    = 4,
  parameter int STAGE_DELAY    = 8,
  parameter int SW_HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   sw_rst_req,
  output logic                   sw_rst_ack,
  output logic [NUM_DOMAINS-1:0] domain_nreset,
  output logic                   rst_done,
  output logic [7:0]             rst_count,
  output logic [2:0]             dbg_state
);

  localparam int CNT_MAX = (STAGE_DELAY > SW_HOLD_CYCLES) ? STAGE_DELAY : SW_HOLD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int IW      = $clog2(NUM_DOMAINS) + 1;

  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(SW_HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_RELEASE = 3'd1,
    ST_DONE    = 3'd2,
    ST_SW_HOLD = 3'd3,
    ST_SW_WAIT = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   done_q, done_d;
  logic                   ack_q, ack_d;
  logic [7:0]             count_q, count_d;
  logic                   nrst_sync;

  // Synchroniser: cleared asynchronously, shifts ones in after nreset rises.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign nrst_sync = sync_q[SYNC_STAGES-1];

  // Software reset handshake (four-phase): sw_rst_req is only sampled in DONE (to start)
  // and SW_WAIT (to finish). sw_rst_ack rises once the hold has elapsed and stays high
  // until sw_rst_req is seen low, at which point ack drops and the release sequence restarts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    ack_d   = ack_q;
    count_d = count_q;

    case (state_q)
      ST_RESET: begin
        if (nrst_sync) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      ST_RELEASE: begin
        if (cnt_q == STAGE_LAST) begin
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (idx_q == IW'(k)) begin
              dom_d[k] = 1'b1;
            end
          end
          cnt_d = '0;
          idx_d = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            if (count_q != 8'hff) begin
              count_d = count_q + 8'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        if (sw_rst_req) begin
          state_d = ST_SW_HOLD;
          dom_d   = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      ST_SW_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_SW_WAIT;
          ack_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_SW_WAIT: begin
        if (!sw_rst_req) begin
          state_d = ST_RELEASE;
          ack_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_RESET;
      sync_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      count_q <= count_d;
    end
  end

  assign domain_nreset = dom_q;
  assign rst_done      = done_q;
  assign sw_rst_ack    = ack_q;
  assign rst_count     = count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sli_reset_sequencer.sv
// Bench for sli_reset_sequencer: timing vector table, hand-written corner sequences and
// random stimulus compared each cycle against a timestamp-based reference model.
module tb_sli_reset_sequencer;

  localparam int SYNC = 2;
  localparam int NDOM = 4;
  localparam int DLY  = 8;
  localparam int HOLD = 4;

  localparam int P_RESET = 0;
  localparam int P_REL   = 1;
  localparam int P_DONE  = 2;
  localparam int P_HOLD  = 3;
  localparam int P_WAIT  = 4;

  // clock / reset
  logic clk        = 1'b0;
  logic nreset     = 1'b1;
  logic sw_rst_req = 1'b0;

  always #5 clk = ~clk;

  logic       sw_rst_ack;
  logic [3:0] domain_nreset;
  logic       rst_done;
  logic [7:0] rst_count;
  logic [2:0] dbg_state;

  logic       ack_c;
  logic [0:0] dom_c;
  logic       done_c;
  logic [7:0] count_c;
  logic [2:0] dbg_c;

  sli_reset_sequencer #(
    .SYNC_STAGES(SYNC), .NUM_DOMAINS(NDOM), .STAGE_DELAY(DLY), .SW_HOLD_CYCLES(HOLD)
  ) u_dut (
    .clk(clk), .nreset(nreset), .sw_rst_req(sw_rst_req), .sw_rst_ack(sw_rst_ack),
    .domain_nreset(domain_nreset), .rst_done(rst_done), .rst_count(rst_count),
    .dbg_state(dbg_state)
  );

  sli_reset_sequencer #(
    .SYNC_STAGES(3), .NUM_DOMAINS(1), .STAGE_DELAY(1), .SW_HOLD_CYCLES(4)
  ) u_dut_c (
    .clk(clk), .nreset(nreset), .sw_rst_req(sw_rst_req), .sw_rst_ack(ack_c),
    .domain_nreset(dom_c), .rst_done(done_c), .rst_count(count_c), .dbg_state(dbg_c)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // reference model: event timestamps, outputs derived arithmetically
  int m_phase    = P_RESET;
  int m_hi       = 0;
  int edge_n     = 0;
  int rel_start  = 0;
  int hold_start = 0;
  int m_count    = 0;

  logic [13:0] exp_q[$];
  logic [13:0] exp_v;

  task automatic model_reset();
    m_phase = P_RESET;
    m_hi    = 0;
    m_count = 0;
  endtask

  task automatic model_step(input logic r);
    case (m_phase)
      P_RESET: begin
        m_hi++;
        if (m_hi == SYNC + 1) begin
          m_phase   = P_REL;
          rel_start = edge_n;
        end
      end
      P_REL: begin
        if ((edge_n - rel_start) / DLY >= NDOM) begin
          m_phase = P_DONE;
          if (m_count < 255) m_count++;
        end
      end
      P_DONE: begin
        if (r) begin
          m_phase    = P_HOLD;
          hold_start = edge_n;
        end
      end
      P_HOLD: begin
        if (edge_n - hold_start == HOLD) m_phase = P_WAIT;
      end
      P_WAIT: begin
        if (!r) begin
          m_phase   = P_REL;
          rel_start = edge_n;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [13:0] model_out();
    logic [3:0] dom;
    int k;
    dom = 4'h0;
    if (m_phase == P_REL) begin
      k = (edge_n - rel_start) / DLY;
      if (k > NDOM) k = NDOM;
      dom = 4'((1 << k) - 1);
    end else if (m_phase == P_DONE) begin
      dom = 4'hf;
    end
    return {dom, (m_phase == P_DONE), (m_phase == P_WAIT), 8'(m_count)};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge nreset);
      if (!nreset && !clk) begin
        model_reset();
        exp_q.delete();
      end else if (clk) begin
        edge_n++;
        if (!nreset) model_reset();
        else model_step(sw_rst_req);
        exp_q.push_back(model_out());
      end
    end
  end

  // scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check("model_dom",   32'(domain_nreset), 32'(exp_v[13:10]));
      check("model_done",  32'(rst_done),      32'(exp_v[9]));
      check("model_ack",   32'(sw_rst_ack),    32'(exp_v[8]));
      check("model_count", 32'(rst_count),     32'(exp_v[7:0]));
    end
  end

  // driver tasks
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_sig(input bit want_done, input int limit, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if ((want_done ? rst_done : sw_rst_ack) == 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL %s: no assertion within %0d cycles, want 1", name, limit);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_dom"},   32'(domain_nreset), 32'h0);
    check({tag, "_done"},  32'(rst_done),      32'h0);
    check({tag, "_ack"},   32'(sw_rst_ack),    32'h0);
    check({tag, "_count"}, 32'(rst_count),     32'h0);
  endtask

  typedef struct {
    logic       req;
    int         adv;
    logic [3:0] dom;
    logic       done;
    logic       ack;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // power-on then soft reset timing, starting from E5
    vecs[0]  = '{1'b0,  5, 4'h0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0,  1, 4'h1, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0,  7, 4'h1, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0,  1, 4'h3, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0,  8, 4'h7, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0,  7, 4'h7, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b0,  1, 4'hf, 1'b1, 1'b0, 8'd1};
    vecs[7]  = '{1'b0,  3, 4'hf, 1'b1, 1'b0, 8'd1};
    vecs[8]  = '{1'b1,  1, 4'h0, 1'b0, 1'b0, 8'd1};
    vecs[9]  = '{1'b1,  3, 4'h0, 1'b0, 1'b0, 8'd1};
    vecs[10] = '{1'b1,  1, 4'h0, 1'b0, 1'b1, 8'd1};
    vecs[11] = '{1'b1,  5, 4'h0, 1'b0, 1'b1, 8'd1};
    vecs[12] = '{1'b0,  1, 4'h0, 1'b0, 1'b0, 8'd1};
    vecs[13] = '{1'b0,  7, 4'h0, 1'b0, 1'b0, 8'd1};
    vecs[14] = '{1'b0,  1, 4'h1, 1'b0, 1'b0, 8'd1};
    vecs[15] = '{1'b0, 16, 4'h7, 1'b0, 1'b0, 8'd1};
    vecs[16] = '{1'b0,  7, 4'h7, 1'b0, 1'b0, 8'd1};
    vecs[17] = '{1'b0,  1, 4'hf, 1'b1, 1'b0, 8'd2};

    #1 nreset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_low("reset");
    check("reset_c_dom",  32'(dom_c),  32'h0);
    check("reset_c_done", 32'(done_c), 32'h0);

    nreset = 1'b1;
    adv(4);
    check("corner_e4_dom",  32'(dom_c),  32'h0);
    check("corner_e4_done", 32'(done_c), 32'h0);
    adv(1);
    check("corner_e5_dom",   32'(dom_c),   32'h1);
    check("corner_e5_done",  32'(done_c),  32'h1);
    check("corner_e5_count", 32'(count_c), 32'h1);

    for (int i = 0; i < 18; i++) begin
      sw_rst_req = vecs[i].req;
      adv(vecs[i].adv);
      check($sformatf("vec%0d_dom", i),   32'(domain_nreset), 32'(vecs[i].dom));
      check($sformatf("vec%0d_done", i),  32'(rst_done),      32'(vecs[i].done));
      check($sformatf("vec%0d_ack", i),   32'(sw_rst_ack),    32'(vecs[i].ack));
      check($sformatf("vec%0d_count", i), 32'(rst_count),     32'(vecs[i].cnt));
    end

    // request pulsed during RELEASE must not disturb release timing
    sw_rst_req = 1'b1;
    wait_sig(1'b0, 20, "ign_ack_wait");
    sw_rst_req = 1'b0;
    adv(1);
    sw_rst_req = 1'b1;
    adv(2);
    sw_rst_req = 1'b0;
    adv(5);
    check("ign_r7_dom", 32'(domain_nreset), 32'h0);
    adv(1);
    check("ign_r8_dom", 32'(domain_nreset), 32'h1);
    adv(24);
    check("ign_r32_dom",   32'(domain_nreset), 32'hf);
    check("ign_r32_done",  32'(rst_done),      32'h1);
    check("ign_r32_count", 32'(rst_count),     32'd3);

    // board reset in the middle of a release sequence
    #2 nreset = 1'b0;
    @(negedge clk);
    adv(2);
    nreset = 1'b1;
    adv(20);
    check("mid_e20_dom", 32'(domain_nreset), 32'h3);
    #2 nreset = 1'b0;
    #1 check_all_low("mid_async");
    @(negedge clk);
    adv(2);
    nreset = 1'b1;
    adv(34);
    check("mid_e34_dom", 32'(domain_nreset), 32'h7);
    adv(1);
    check("mid_e35_dom",   32'(domain_nreset), 32'hf);
    check("mid_e35_done",  32'(rst_done),      32'h1);
    check("mid_e35_count", 32'(rst_count),     32'd1);

    // saturation of the completed-sequence counter
    for (int i = 0; i < 260; i++) begin
      sw_rst_req = 1'b1;
      wait_sig(1'b0, 20, "sat_ack_wait");
      sw_rst_req = 1'b0;
      wait_sig(1'b1, 60, "sat_done_wait");
    end
    check("sat_count", 32'(rst_count), 32'd255);
    check("sat_done",  32'(rst_done),  32'h1);

    // random requests and board resets, checked by the scoreboard every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) sw_rst_req = ~sw_rst_req;
      if (nreset && $urandom_range(0, 299) == 0) begin
        #2 nreset = 1'b0;
        #1 check_all_low("rnd_async");
      end else if (!nreset && $urandom_range(0, 3) == 0) begin
        nreset = 1'b1;
      end
    end

    sw_rst_req = 1'b0;
    nreset     = 1'b1;
    adv(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
